// File: rtl/pll_nco_clkgen.sv
// Multi-channel NCO clock generator: one phase accumulator per channel drives a
// square-wave clock and a rising-edge tick, reconfigurable through valid/ready.
module pll_nco_clkgen #(
    parameter int NUM_CLOCKS  = 2,
    parameter int ACC_WIDTH   = 32,
    parameter int LOCK_CYCLES = 1024,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = {1'b1, {(ACC_WIDTH-1){1'b0}}},
    localparam int CHAN_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CHAN_W-1:0]     cfg_chan,
    input  logic [ACC_WIDTH-1:0]  cfg_inc,
    input  logic [ACC_WIDTH-1:0]  cfg_phase,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_tick,
    output logic                  locked
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {
        SETTLE,
        IDLE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]  acc_q [NUM_CLOCKS];
    logic [ACC_WIDTH-1:0]  acc_d [NUM_CLOCKS];
    logic [ACC_WIDTH-1:0]  inc_q [NUM_CLOCKS];
    logic [ACC_WIDTH-1:0]  inc_d [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] tick_q, tick_d;
    logic                  chan_ok;
    logic                  cfg_hit;

    // Out-of-range channel requests are still handshaken but change nothing.
    assign chan_ok = ({1'b0, cfg_chan} < (CHAN_W + 1)'(NUM_CLOCKS));
    assign cfg_hit = cfg_valid && (state_q == IDLE) && chan_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SETTLE: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                if (cfg_hit) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    // A load replaces the increment step; the tick follows any MSB 0->1 change.
    always_comb begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            acc_d[i]  = acc_q[i] + inc_q[i];
            inc_d[i]  = inc_q[i];
            if (cfg_hit && (cfg_chan == CHAN_W'(i))) begin
                acc_d[i] = cfg_phase;
                inc_d[i] = cfg_inc;
            end
            tick_d[i] = ~acc_q[i][ACC_WIDTH-1] & acc_d[i][ACC_WIDTH-1];
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            tick_q  <= '0;
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= DEFAULT_INC;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                acc_q[i] <= acc_d[i];
                inc_q[i] <= inc_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            outclk[i] = acc_q[i][ACC_WIDTH-1];
        end
    end

    assign outclk_tick = tick_q;
    assign locked      = (state_q == IDLE);
    assign cfg_ready   = (state_q == IDLE);

endmodule

// File: tb/tb_pll_nco_clkgen.sv
// Bench for pll_nco_clkgen: cycle scoreboard from a reference model, a vector
// table of reconfigurations with tick-count windows, and hand-written corners.
module tb_pll_nco_clkgen;

    localparam int NC = 3;
    localparam int LC = 16;
    localparam logic [31:0] DEF_INC = 32'h8000_0000;

    logic          refclk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_chan;
    logic [31:0]   cfg_inc;
    logic [31:0]   cfg_phase;
    logic [NC-1:0] outclk;
    logic [NC-1:0] outclk_tick;
    logic          locked;

    int nVec = 0;
    int nErr = 0;

    pll_nco_clkgen #(
        .NUM_CLOCKS (NC),
        .ACC_WIDTH  (32),
        .LOCK_CYCLES(LC)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_inc    (cfg_inc),
        .cfg_phase  (cfg_phase),
        .outclk     (outclk),
        .outclk_tick(outclk_tick),
        .locked     (locked)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic [NC-1:0] clk;
        logic [NC-1:0] tick;
        logic          lck;
    } exp_t;

    exp_t expQ[$];

    typedef struct {
        int          chan;
        logic [31:0] inc;
        logic [31:0] phase;
        int          window;
        int          expT0;
        int          expT1;
    } vec_t;

    vec_t vecs[3];

    logic [31:0] mAcc [NC];
    logic [31:0] mInc [NC];
    logic        mSettle;
    int          mCnt;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each refclk edge and queues the outputs
    // the DUT should show during the following cycle.
    always begin
        exp_t        e;
        logic        hit;
        logic [31:0] nxt;
        @(posedge refclk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) begin
                mAcc[i] = '0;
                mInc[i] = DEF_INC;
            end
            mSettle = 1'b1;
            mCnt    = 0;
            expQ.delete();
        end else begin
            hit = !mSettle && cfg_valid && (int'(cfg_chan) < NC);
            for (int i = 0; i < NC; i++) begin
                nxt = (hit && int'(cfg_chan) == i) ? cfg_phase : mAcc[i] + mInc[i];
                e.tick[i] = !mAcc[i][31] && nxt[31];
                e.clk[i]  = nxt[31];
                mAcc[i]   = nxt;
                if (hit && int'(cfg_chan) == i) mInc[i] = cfg_inc;
            end
            if (mSettle) begin
                if (mCnt == LC - 1) mSettle = 1'b0;
                else mCnt++;
            end else if (hit) begin
                mSettle = 1'b1;
                mCnt    = 0;
            end
            e.lck = !mSettle;
            expQ.push_back(e);
        end
    end

    // Scoreboard: compare the DUT against the oldest queued expectation.
    always begin
        exp_t e;
        @(negedge refclk);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("sb_outclk", 64'(outclk), 64'(e.clk));
            checkOutput("sb_tick", 64'(outclk_tick), 64'(e.tick));
            checkOutput("sb_locked", 64'(locked), 64'(e.lck));
            checkOutput("sb_ready", 64'(cfg_ready), 64'(e.lck));
        end
    end

    // Hold a request until it is taken; returns in the cycle after the handshake.
    task automatic applyStimulus(input int chan, input logic [31:0] inc, input logic [31:0] phase);
        logic taken = 1'b0;
        cfg_chan  = 2'(chan);
        cfg_inc   = inc;
        cfg_phase = phase;
        cfg_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (cfg_ready) begin
                taken = 1'b1;
                break;
            end
            @(negedge refclk);
        end
        if (taken) @(negedge refclk);
        checkOutput("handshake_taken", 64'(taken), 64'd1);
        cfg_valid = 1'b0;
    endtask

    task automatic waitReady();
        logic seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (cfg_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge refclk);
        end
        checkOutput("ready_timeout", 64'(seen), 64'd1);
    endtask

    task automatic countTicks(input int n, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        repeat (n) begin
            @(negedge refclk);
            c0 += int'(outclk_tick[0]);
            c1 += int'(outclk_tick[1]);
        end
    endtask

    // Called at the negedge where rst_n is released.
    task automatic checkSettle(input string name);
        int highs = 0;
        repeat (LC - 1) begin
            @(negedge refclk);
            if (locked || cfg_ready) highs++;
        end
        checkOutput({name, "_low"}, 64'(highs), 64'd0);
        @(negedge refclk);
        checkOutput({name, "_locked"}, 64'(locked), 64'd1);
        checkOutput({name, "_ready"}, 64'(cfg_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0, c1, mis, t0, t1, lows;

        vecs[0] = '{chan: 1, inc: 32'h4000_0000, phase: 32'h0, window: 40,  expT0: 20,  expT1: 10};
        vecs[1] = '{chan: 0, inc: 32'h5555_5556, phase: 32'h0, window: 900, expT0: 300, expT1: 225};
        vecs[2] = '{chan: 0, inc: 32'h0, phase: 32'h8000_0000, window: 20, expT0: 0, expT1: 5};

        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_inc   = '0;
        cfg_phase = '0;
        repeat (3) @(negedge refclk);
        checkOutput("rst_outclk", 64'(outclk), 64'd0);
        checkOutput("rst_tick", 64'(outclk_tick), 64'd0);
        checkOutput("rst_locked", 64'(locked), 64'd0);
        checkOutput("rst_ready", 64'(cfg_ready), 64'd0);

        rst_n = 1'b1;
        checkSettle("settle0");
        countTicks(10, c0, c1);
        checkOutput("default_ticks0", 64'(c0), 64'd5);
        checkOutput("default_ticks1", 64'(c1), 64'd5);

        for (int v = 0; v < 3; v++) begin
            applyStimulus(vecs[v].chan, vecs[v].inc, vecs[v].phase);
            checkOutput("cfg_drops_lock", 64'(locked), 64'd0);
            waitReady();
            countTicks(vecs[v].window, c0, c1);
            checkOutput("vec_ticks0", 64'(c0), 64'(vecs[v].expT0));
            checkOutput("vec_ticks1", 64'(c1), 64'(vecs[v].expT1));
        end
        checkOutput("frozen_outclk0", 64'(outclk[0]), 64'd1);

        // Back-to-back loads chosen so ch0 sits at 0 when ch1 is loaded at half a turn.
        applyStimulus(0, 32'h2000_0000, 32'hE000_0000);
        applyStimulus(1, 32'h2000_0000, 32'h8000_0000);
        waitReady();
        mis = 0; t0 = -1; t1 = -1; c0 = 0; c1 = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge refclk);
            if (outclk[1] == outclk[0]) mis++;
            if (outclk_tick[0]) begin
                c0++;
                if (t0 < 0) t0 = k;
            end
            if (outclk_tick[1]) begin
                c1++;
                if (t1 < 0) t1 = k;
            end
        end
        checkOutput("antiphase_mismatch", 64'(mis), 64'd0);
        checkOutput("antiphase_ticks0", 64'(c0), 64'd5);
        checkOutput("antiphase_ticks1", 64'(c1), 64'd5);
        checkOutput("antiphase_spacing", 64'(((t1 - t0) + 8) % 8), 64'd4);

        applyStimulus(3, 32'h0000_0001, 32'h0000_0001);
        checkOutput("oor_locked", 64'(locked), 64'd1);
        lows = 0;
        repeat (5) begin
            @(negedge refclk);
            if (!locked || !cfg_ready) lows++;
        end
        checkOutput("oor_lock_held", 64'(lows), 64'd0);
        countTicks(16, c0, c1);
        checkOutput("oor_ticks0", 64'(c0), 64'd2);
        checkOutput("oor_ticks1", 64'(c1), 64'd2);

        applyStimulus(1, 32'h1000_0000, 32'h1234_5678);
        checkOutput("midrst_cfg_lock", 64'(locked), 64'd0);
        repeat (7) @(negedge refclk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_outclk", 64'(outclk), 64'd0);
        checkOutput("midrst_tick", 64'(outclk_tick), 64'd0);
        checkOutput("midrst_locked", 64'(locked), 64'd0);
        checkOutput("midrst_ready", 64'(cfg_ready), 64'd0);
        repeat (3) @(negedge refclk);
        rst_n = 1'b1;
        checkSettle("settle1");
        countTicks(8, c0, c1);
        checkOutput("midrst_ticks0", 64'(c0), 64'd4);
        checkOutput("midrst_ticks1", 64'(c1), 64'd4);

        repeat (2) @(negedge refclk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
